regfile_sb: RTL



---
 rtl/regfile_sb.sv | 81 ++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/one-write register file with per-entry pending (scoreboard) bits and a post-reset clear sequence
//   clk          rising-edge clock
//   reset        synchronous active-low reset; restarts the clear sequence
//   we/wsel/wdata write port; also clears pending[wsel]
//   rsv/rsel     reserve port; sets pending[rsel]
//   asel/bsel    read selects; adata/bdata and apend/bpend are combinational
//   ready        low while clearing, high once every entry has been zeroed
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_IDX = (1 << AW) - 1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wsel,
    input  logic [DW-1:0] wdata,
    input  logic          rsv,
    input  logic [AW-1:0] rsel,
    input  logic [AW-1:0] asel,
    input  logic [AW-1:0] bsel,
    output logic [DW-1:0] adata,
    output logic [DW-1:0] bdata,
    output logic          apend,
    output logic          bpend,
    output logic          ready
);
    localparam int N = 1 << AW;
    localparam logic [AW-1:0] ZI = AW'(ZERO_IDX);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t          state_q;
    logic [AW:0]     ctr_q;
    logic            ready_q;
    logic [DW-1:0]   regs_q [N];
    logic [N-1:0]    pend_q, pend_d;
    logic [AW-1:0]   ctr_idx;
    logic            wr, rs, zero_a, zero_b, fwd_a, fwd_b;
    assign ctr_idx = ctr_q[AW-1:0];
    // ready_q doubles as the RUN indicator; reset gating keeps a RUN-state write from landing on the reset edge
    assign wr = reset && ready_q && we && !(ZERO_EN && wsel == ZI);
    assign rs = reset && ready_q && rsv && !(ZERO_EN && rsel == ZI);
    // counter is one bit wider than the index so the terminal compare cannot alias back to entry 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            ctr_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            ctr_q <= ctr_q + (AW+1)'(1);
            if (ctr_q == (AW+1)'(N-1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) regs_q[ctr_idx] <= '0;
        else if (wr) regs_q[wsel] <= wdata;
    end
    // reservation applied after the write so a same-cycle write+reserve leaves the entry pending
    always_comb begin
        pend_d = pend_q;
        if (state_q == CLEAR) pend_d[ctr_idx] = 1'b0;
        else begin
            if (wr) pend_d[wsel] = 1'b0;
            if (rs) pend_d[rsel] = 1'b1;
        end
    end
    always_ff @(posedge clk) pend_q <= pend_d;
    assign zero_a = ZERO_EN && asel == ZI;
    assign zero_b = ZERO_EN && bsel == ZI;
    assign fwd_a  = BYPASS && ready_q && we && wsel == asel;
    assign fwd_b  = BYPASS && ready_q && we && wsel == bsel;
    assign adata  = (!ready_q || zero_a) ? '0 : fwd_a ? wdata : regs_q[asel];
    assign bdata  = (!ready_q || zero_b) ? '0 : fwd_b ? wdata : regs_q[bsel];
    assign apend  = ready_q && !zero_a && !fwd_a && pend_q[asel];
    assign bpend  = ready_q && !zero_b && !fwd_b && pend_q[bsel];
    assign ready  = ready_q;
endmodule
